// File: rtl/jk_register_sequencer.sv
// rtl/jk_register_sequencer.sv - command sequencer driving a WIDTH-bit JK flip-flop register
// CLEAR/LOAD/COUNT_UP/COUNT_DOWN over valid/ready; j/k generated every cycle, q updated by the JK rule.
module jk_register_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             halt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;
  localparam logic [1:0] OP_DOWN  = 2'b11;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             wrap_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             is_count;
  logic             step;
  logic             wrap_hit;
  logic             last_step;

  // Toggle masks: bit i flips when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    up_t    = '0;
    dn_t    = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_q[i-1];
      dn_t[i] = dn_t[i-1] & ~q_q[i-1];
    end
  end

  assign is_count  = op_q[1];
  assign step      = (state_q == S_EXEC) && is_count && !halt;
  assign wrap_hit  = step && ((op_q == OP_DOWN) ? (q_q == '0) : (&q_q));
  assign last_step = (rem_q == WIDTH'(1));

  always_comb begin
    j_d = '0;
    k_d = '0;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_CLEAR: k_d = '1;
        OP_LOAD: begin
          j_d = data_q;
          k_d = ~data_q;
        end
        OP_UP: begin
          if (!halt) begin
            j_d = up_t;
            k_d = up_t;
          end
        end
        OP_DOWN: begin
          if (!halt) begin
            j_d = dn_t;
            k_d = dn_t;
          end
        end
        default: ;
      endcase
    end
  end

  assign q_d = (j_d & ~q_q) | (~k_d & q_q);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLEAR;
      data_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      q_q <= q_d;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            rem_q   <= cmd_data;
            wrap_q  <= 1'b0;
            ready_q <= 1'b0;
            if (cmd_op[1] && (cmd_data == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_EXEC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (step) begin
            rem_q <= rem_q - WIDTH'(1);
          end
          if (wrap_hit) begin
            wrap_q <= 1'b1;
          end
          if (!is_count || halt || last_step) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign j         = j_d;
  assign k         = k_d;
  assign q         = q_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign cmd_ready = ready_q;

endmodule
